// File: rtl/axi_stream_slave_fifo_if.sv
// AXI4-Stream beat channel carried between an upstream master and the slave FIFO.
interface axi_stream_slave_fifo_if #(
    parameter int unsigned byte_width = 4
);
    logic                    tvalid;
    logic                    tready;
    logic [8*byte_width-1:0] tdata;
    logic [byte_width-1:0]   tkeep;
    logic [byte_width-1:0]   tstrb;
    logic                    tlast;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tstrb,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tstrb,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axi_stream_slave_fifo.sv
// AXI4-Stream receiver: buffers beats in a synchronous FIFO, drops null beats,
// and keeps packet/byte/null-drop statistics plus a sticky TSTRB/TKEEP error flag.
module axi_stream_slave_fifo #(
    parameter int unsigned byte_width = 4,
    parameter int unsigned depth_log2 = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    axi_stream_slave_fifo_if.slave  s,
    output logic                    out_valid,
    input  logic                    out_pop,
    output logic [8*byte_width-1:0] out_data,
    output logic [byte_width-1:0]   out_keep,
    output logic [byte_width-1:0]   out_strb,
    output logic                    out_last,
    output logic [depth_log2:0]     fill_level,
    output logic [31:0]             pkt_count,
    output logic [31:0]             byte_count,
    output logic [15:0]             null_drop_count,
    output logic                    proto_err
);
    localparam int unsigned depth = 1 << depth_log2;
    localparam int unsigned dw    = 8 * byte_width;

    logic [dw-1:0]         mem_data [depth];
    logic [byte_width-1:0] mem_keep [depth];
    logic [byte_width-1:0] mem_strb [depth];
    logic                  mem_last [depth];

    logic [depth_log2:0]   wr_ptr;
    logic [depth_log2:0]   rd_ptr;
    logic [depth_log2-1:0] wr_idx;
    logic [depth_log2-1:0] rd_idx;

    logic full;
    logic empty;
    logic accept;
    logic is_null;
    logic store;
    logic pop;

    function automatic logic [31:0] popcount(input logic [byte_width-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int unsigned i = 0; i < byte_width; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

    assign wr_idx = wr_ptr[depth_log2-1:0];
    assign rd_idx = rd_ptr[depth_log2-1:0];

    assign full  = (wr_ptr[depth_log2] != rd_ptr[depth_log2]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);

    // Ready depends only on reset and pointer registers, never on tvalid,
    // so a full FIFO cannot take a beat even when a pop happens in the same cycle.
    assign s.tready = !reset && !full;

    assign accept  = s.tvalid && s.tready;
    assign is_null = (s.tkeep == '0) && !s.tlast;
    assign store   = accept && !is_null;
    assign pop     = out_pop && !empty;

    assign out_valid  = !empty;
    assign out_data   = mem_data[rd_idx];
    assign out_keep   = mem_keep[rd_idx];
    assign out_strb   = mem_strb[rd_idx];
    assign out_last   = mem_last[rd_idx];
    assign fill_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (store) begin
            mem_data[wr_idx] <= s.tdata;
            mem_keep[wr_idx] <= s.tkeep;
            mem_strb[wr_idx] <= s.tstrb;
            mem_last[wr_idx] <= s.tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count       <= '0;
            byte_count      <= '0;
            null_drop_count <= '0;
            proto_err       <= 1'b0;
        end else if (accept) begin
            if (s.tlast) begin
                pkt_count <= pkt_count + 32'd1;
            end
            byte_count <= byte_count + popcount(s.tkeep);
            if (is_null && (null_drop_count != '1)) begin
                null_drop_count <= null_drop_count + 16'd1;
            end
            if ((s.tstrb & ~s.tkeep) != '0) begin
                proto_err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/axi_stream_slave_fifo.md
# axi_stream_slave_fifo

AXI4-Stream receiver (slave port) that accepts beats into a synchronous FIFO, exposes them on a simple pop interface, and keeps packet/byte statistics plus a sticky protocol-error flag. Sits at the consuming end of any AXI-Stream link in the design, as the ingress to register-mapped or DMA-style logic. Byte qualification follows AXI4-Stream TKEEP/TSTRB semantics (Section 2.4.3).

## Interface
Parameters:
- byte_width, 4: TDATA width in bytes (≥1).
- depth_log2, 2: FIFO depth = 2^depth_log2 entries (depth_log2 ≥ 1).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  FIFO can accept.
- s_tdata  in  8*byte_width  payload.
- s_tkeep  in  byte_width  byte kept.
- s_tstrb  in  byte_width  byte is data (vs position).
- s_tlast  in  1  last beat of packet.
- out_valid  out  1  FIFO non-empty.
- out_pop  in  1  consume head entry.
- out_data  out  8*byte_width  head payload.
- out_keep  out  byte_width  head TKEEP.
- out_strb  out  byte_width  head TSTRB.
- out_last  out  1  head TLAST.
- fill_level  out  depth_log2+1  entries stored.
- pkt_count  out  32  packets accepted (accepted beats with TLAST).
- byte_count  out  32  sum of popcount(TKEEP) over accepted beats.
- null_drop_count  out  16  null beats discarded.
- proto_err  out  1  sticky: accepted beat with TSTRB set where TKEEP clear.

## Operation
- Accept = s_tvalid && s_tready at a rising edge.
- s_tready = !reset && (fill_level < 2^depth_log2); driven from registers only, no combinational path from s_tvalid.
- Null beat (TKEEP == 0, TLAST == 0): accepted but not stored; null_drop_count += 1 (saturates at 0xFFFF); pkt_count and byte_count unchanged.
- Null beat with TLAST == 1: stored (marks packet end); pkt_count += 1.
- All other accepted beats: data/keep/strb/last written at tail; byte_count += popcount(TKEEP); pkt_count += 1 if TLAST.
- pkt_count, byte_count wrap modulo 2^32.
- proto_err set on any accepted beat with (TSTRB & ~TKEEP) != 0, including null beats; beat otherwise handled normally; cleared only by reset.
- Pop: out_pop && out_valid advances head; out_pop while empty ignored, no state change.
- out_data/keep/strb/last present the head entry combinationally from storage; undefined-but-stable when out_valid = 0.
- Pointers depth_log2+1 bits wide, wrap naturally; full = MSBs differ, low bits equal.

## Timing
- Reset: fill_level = 0, out_valid = 0, s_tready = 0 while reset high, all counters 0, proto_err = 0. s_tready = 1 in first cycle after reset deasserts.
- Reset mid-packet: FIFO contents discarded; a partially received packet is not counted.
- Latency: beat accepted at edge N → out_valid = 1 and fields visible after edge N; counters updated after edge N.
- Simultaneous accept and pop in same cycle: fill_level unchanged (or −1 if accepted beat is a dropped null beat).
- Full: s_tready = 0; a pop at edge N raises s_tready after edge N. No pass-through into a full FIFO in the same cycle.
- Empty: accept at N then pop at N+1 valid; single-entry occupancy works with no bubble.
- Upstream held-stable data during s_tvalid && !s_tready is required of the master, not checked here.

## Test plan
- Reset then single beat tdata=0xDEADBEEF, tkeep=0xF, tlast=1 → out_valid=1 next cycle, out_data=0xDEADBEEF, pkt_count=1, byte_count=4, fill_level=1.
- Push 4 beats without popping (depth_log2=2) → s_tready=0 after 4th accept, fill_level=4; a 5th beat held valid is accepted only after one pop; output order preserved.
- Continuous accept and pop every cycle for 100 beats with tkeep=0x3 → fill_level stays ≤1, byte_count=200, no lost or duplicated beat.
- Beat with tkeep=0x0, tlast=0 → not stored, null_drop_count=1, fill_level unchanged; tkeep=0x0, tlast=1 → stored, pkt_count+1.
- Beat with tkeep=0x3, tstrb=0x7 → proto_err=1 and remains 1 after 10 clean beats; clears only on reset.
- Reset asserted with 3 entries stored → next cycle fill_level=0, out_valid=0, counters 0, s_tready=0 until reset deasserts.
